nn_weight_loader: RTL

Sequencer that streams weight words from a host-side valid/ready source onto the shared `bus` of the two-layer network and pulses the per-node shift-register enables `we` one node at a time. It sits beside the network top level, owns every bit of `we`, and is the only driver of `bus` while loading. A load walks layer 1 (nodes `sl1`, `sx` words each) and then the output layer (nodes `sl`, `sl1` words each). It signals completion so training/inference control can resume.

---
 rtl/nn_pkg.sv | 18 +
 rtl/nn_load_counter.sv | 46 ++++
 rtl/nn_weight_loader.sv | 111 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the two-layer network weight loader.
// Word width follows the fixed-point width macro `FXP_N (defaults to 16 when not provided).
`ifndef FXP_N
`define FXP_N 16
`endif

package nn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  localparam int WORD_W = 2 * `FXP_N;

  // Last word index for a node: layer-1 nodes take sx words, output-layer nodes take sl1.
  function automatic int word_limit(input int idx, input int sx, input int sl1);
    return (idx < sl1) ? sx - 1 : sl1 - 1;
  endfunction

endpackage

// File: rtl/nn_load_counter.sv
// Word/node position tracker for the weight loader; the words-per-node limit
// depends on which layer the current node belongs to.
module nn_load_counter
  import nn_pkg::*;
#(
  parameter int sx  = 2,
  parameter int sl1 = 3,
  parameter int sl  = 2,
  parameter int nd  = sl1 + sl,
  parameter int WCW = 1,
  parameter int NW  = 1
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  output logic [WCW-1:0] wc,
  output logic [NW-1:0]  node_idx,
  output logic           last_word,
  output logic           last_node
);

  logic [WCW-1:0] lim;

  assign lim       = WCW'(word_limit(int'(node_idx), sx, sl1));
  assign last_word = (wc == lim);
  assign last_node = (node_idx == NW'(nd - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc       <= '0;
      node_idx <= '0;
    end else if (clr) begin
      wc       <= '0;
      node_idx <= '0;
    end else if (inc) begin
      if (last_word) begin
        wc       <= '0;
        node_idx <= last_node ? '0 : node_idx + NW'(1);
      end else begin
        wc <= wc + WCW'(1);
      end
    end
  end

endmodule

// File: rtl/nn_weight_loader.sv
// Streams weight words from a valid/ready source onto the network bus, pulsing one
// node shift enable per word. Optional running checksum under NN_LOADER_CHECKSUM_EN.
`ifndef FXP_N
`define FXP_N 16
`endif

module nn_weight_loader
  import nn_pkg::*;
#(
  parameter int n   = `FXP_N,
  parameter int sx  = 2,
  parameter int sl1 = 3,
  parameter int sl  = 2,
  parameter int nd  = sl1 + sl,
  localparam int NW   = (nd > 1) ? $clog2(nd) : 1,
  localparam int MAXW = (sx > sl1) ? sx : sl1,
  localparam int WCW  = (MAXW > 1) ? $clog2(MAXW) : 1
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  input  logic [2*n-1:0]  in_data,
  output logic            in_ready,
  output logic [nd-1:0]   we,
  output logic [2*n-1:0]  bus_out,
  output logic            bus_oe,
  output logic            busy,
  output logic            done,
  output logic [NW-1:0]   node_idx
`ifdef NN_LOADER_CHECKSUM_EN
  ,
  output logic [2*n-1:0]  checksum
`endif
);

  state_t         state;
  logic           acc;
  logic           ctr_clr;
  logic           last_word;
  logic           last_node;
  logic [WCW-1:0] wc;
  logic [nd-1:0]  sel;

  assign in_ready = (state == LOAD) && !abort;
  assign acc      = in_valid && in_ready;
  // Counters sit at zero outside LOAD, which also covers the abort clear.
  assign ctr_clr  = (state != LOAD) || abort;
  // Node 0 owns the top enable bit; later nodes walk down toward we[0].
  assign sel      = {{(nd-1){1'b0}}, 1'b1} << (NW'(nd - 1) - node_idx);

  nn_load_counter #(
    .sx(sx), .sl1(sl1), .sl(sl), .nd(nd), .WCW(WCW), .NW(NW)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (ctr_clr),
    .inc       (acc),
    .wc        (wc),
    .node_idx  (node_idx),
    .last_word (last_word),
    .last_node (last_node)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      we      <= '0;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      we     <= acc ? sel : '0;
      bus_oe <= acc;
      if (acc) bus_out <= in_data;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (acc && last_word && last_node) begin
          state <= FINISH;
          done  <= 1'b1;
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NN_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (acc)                    checksum <= checksum + in_data;
  end
`endif

endmodule
